ysyx_24100006_clint: RTL
========================

YSYX_24100006_CLINT -- requirements
Module: ysyx_24100006_clint

Interface
REQ-001 SHALL have parameter CTRL_RESET, default 32'h0000_0001, reset value of CTRL (bit0 enable, bits[15:8] prescale divisor).
REQ-002 SHALL have parameter MTIMECMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, reset value of MTIMECMP.
REQ-003 SHALL have ports:
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  axi_arvalid/axi_arready  in/out  1/1  read-address handshake
  axi_araddr  in  32  read address (only [4:2] decoded)
  axi_arlen  in  8  read burst length minus 1
  axi_rvalid/axi_rready  out/in  1/1  read-data handshake
  axi_rdata  out  32  read data
  axi_rresp  out  2  read response
  axi_rlast  out  1  last read beat
  axi_awvalid/axi_awready  in/out  1/1  write-address handshake
  axi_awaddr  in  32  write address (only [4:2] decoded)
  axi_wvalid/axi_wready  in/out  1/1  write-data handshake
  axi_wdata  in  32  write data
  axi_wstrb  in  4  byte enables
  axi_wlast  in  1  last write beat
  axi_bvalid/axi_bready  out/in  1/1  write-response handshake
  axi_bresp  out  2  write response
  timer_irq  out  1  mtime >= mtimecmp
Registers by addr[4:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL; 5-7 unmapped.

Function
REQ-004 SHALL run read FSM R_IDLE -> R_DATA -> R_IDLE; R_IDLE drives arready=1, rvalid=0.
REQ-005 SHALL, on arvalid&&arready, latch address and arlen, clear beat counter, load first beat data/resp into output registers, enter R_DATA next cycle.
REQ-006 SHALL in R_DATA hold rvalid=1 and rdata/rresp/rlast stable until rready; rlast=1 iff beat==latched arlen.
REQ-007 SHALL, on rvalid&&rready with beat<arlen, increment address by 4 and beat by 1 and present next beat in following cycle with rvalid held high; with beat==arlen, return to R_IDLE.
REQ-008 SHALL, when reading MTIME_LO, snapshot MTIME_HI into a shadow register; reads of MTIME_HI return the shadow (value zero after reset).
REQ-009 SHALL return rresp=2'b00 for mapped offsets and rresp=2'b10 (SLVERR) with rdata=0 for unmapped offsets, per beat.
REQ-010 SHALL run write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; W_IDLE: awready=1, wready=0, bvalid=0.
REQ-011 SHALL in W_DATA drive wready=1; each wvalid beat writes the addressed register under wstrb (unselected bytes keep old value), then address += 4.
REQ-012 SHALL enter W_RESP after the beat with wlast=1; bresp=2'b10 if any beat hit an unmapped offset, else 2'b00; unmapped writes have no effect.
REQ-013 SHALL hold bvalid=1 in W_RESP until bready, then return to W_IDLE.
REQ-014 SHALL allow read and write FSMs to operate concurrently; same-cycle read and write of one register returns the pre-write value.
REQ-015 SHALL, when CTRL[0]=1, count prescaler 0..CTRL[15:8]; on match clear prescaler and increment 64-bit MTIME; divisor 0 increments every cycle.
REQ-016 SHALL wrap MTIME from 64'hFFFF_FFFF_FFFF_FFFF to 0 without flag.
REQ-017 SHALL, when a bus write to MTIME_LO/HI coincides with an increment, apply the write and suppress that increment.
REQ-018 SHALL, when CTRL[0]=0, hold MTIME and prescaler; writing CTRL clears prescaler.
REQ-019 SHALL register timer_irq = (MTIME >= MTIMECMP) unsigned 64-bit, one cycle after the compared values change.

Reset
REQ-020 SHALL on reset low asynchronously force: R_IDLE, W_IDLE, rvalid=0, bvalid=0, rlast=0, rdata=0, rresp=0, bresp=0, MTIME=0, shadow=0, prescaler=0, CTRL=CTRL_RESET, MTIMECMP=MTIMECMP_RESET, timer_irq=0.
REQ-021 SHALL abandon any in-flight transaction on reset without issuing rvalid/bvalid afterwards.

Verification
REQ-022 Reset release, no traffic, CTRL=1 -> MTIME reads 10 at cycle 10 (±1 handshake latency); timer_irq=0.
REQ-023 Write MTIMECMP_LO=5, MTIMECMP_HI=0 -> timer_irq rises exactly one cycle after MTIME reaches 5.
REQ-024 Read burst arlen=3 at offset 0x0 with rready toggling -> 4 beats MTIME_LO, shadow HI, CMP_LO, CMP_HI; rlast only on 4th; data stable while stalled.
REQ-025 Write MTIME=64'hFFFF_FFFF_FFFF_FFFE, divisor 0 -> wraps to 0 two cycles later; write coinciding with increment lands exact value.
REQ-026 Read/write offset 0x18 -> rresp=2'b10, rdata=0; bresp=2'b10; no register changes.
REQ-027 Assert reset mid-burst during R_DATA and W_DATA -> all outputs at reset values immediately; next transaction completes normally.

Source files
------------

// File: rtl/ysyx_24100006_clint.sv
// Core-local interruptor: 64-bit prescaled MTIME, MTIMECMP compare and timer IRQ,
// accessed through an AXI slave with independent read and write burst engines.
module ysyx_24100006_clint #(
    parameter logic [31:0] CTRL_RESET     = 32'h0000_0001,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    output logic [1:0]  axi_bresp,
    output logic        timer_irq
);
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 64;
    localparam int unsigned PW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned OW = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } rstate_t;
    typedef enum logic [1:0] { W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2 } wstate_t;

    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_v,
                                              input logic [DW-1:0] new_v,
                                              input logic [3:0]    strb);
        logic [DW-1:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // Architectural state
    logic [TW-1:0] r_mtime;
    logic [TW-1:0] r_mtimecmp;
    logic [DW-1:0] r_ctrl;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_shadow;
    logic          r_irq;

    // Read engine
    rstate_t       r_rstate, w_rstate_nxt;
    logic [DW-1:0] r_raddr;
    logic [LW-1:0] r_rlen, r_rbeat;
    logic [DW-1:0] r_rdata;
    logic [1:0]    r_rresp;
    logic          r_rlast;
    logic          w_rd_load;
    logic [DW-1:0] w_rd_addr;
    logic [LW-1:0] w_rd_beat, w_rd_len;
    logic [DW-1:0] w_rd_val;
    logic          w_rd_err;

    // Write engine
    wstate_t       r_wstate, w_wstate_nxt;
    logic [DW-1:0] r_waddr;
    logic          r_werr;
    logic [1:0]    r_bresp;
    logic          w_aw_hs, w_w_hs;
    logic [OW-1:0] w_wr_off;
    logic          w_wr_bad;
    logic [4:0]    w_wr_sel;

    // Timer
    logic          w_tick;
    logic [TW-1:0] w_mtime_nxt;
    logic [PW-1:0] w_presc_nxt;

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_load    = 1'b0;
        w_rd_addr    = r_raddr;
        w_rd_beat    = r_rbeat;
        w_rd_len     = r_rlen;
        case (r_rstate)
            R_IDLE: begin
                if (axi_arvalid) begin
                    w_rd_load    = 1'b1;
                    w_rd_addr    = axi_araddr;
                    w_rd_beat    = '0;
                    w_rd_len     = axi_arlen;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    if (r_rbeat != r_rlen) begin
                        w_rd_load = 1'b1;
                        w_rd_addr = r_raddr + DW'(4);
                        w_rd_beat = r_rbeat + LW'(1);
                    end else begin
                        w_rstate_nxt = R_IDLE;
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Register file read mux; MTIME_HI reads come from the shadow so LO/HI pairs are coherent
    always_comb begin
        w_rd_val = '0;
        w_rd_err = 1'b0;
        case (w_rd_addr[4:2])
            3'd0:    w_rd_val = r_mtime[31:0];
            3'd1:    w_rd_val = r_shadow;
            3'd2:    w_rd_val = r_mtimecmp[31:0];
            3'd3:    w_rd_val = r_mtimecmp[63:32];
            3'd4:    w_rd_val = r_ctrl;
            default: w_rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rbeat  <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
            r_shadow <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_rd_load) begin
                r_raddr <= w_rd_addr;
                r_rbeat <= w_rd_beat;
                r_rlen  <= w_rd_len;
                r_rdata <= w_rd_val;
                r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                r_rlast <= (w_rd_beat == w_rd_len);
                if (w_rd_addr[4:2] == 3'd0) r_shadow <= r_mtime[63:32];
            end
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_aw_hs      = 1'b0;
        w_w_hs       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (axi_awvalid) begin
                    w_aw_hs      = 1'b1;
                    w_wstate_nxt = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid) begin
                    w_w_hs = 1'b1;
                    if (axi_wlast) w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_wr_off = r_waddr[4:2];
        w_wr_bad = (w_wr_off > 3'd4);
        w_wr_sel = '0;
        if (w_w_hs) begin
            case (w_wr_off)
                3'd0:    w_wr_sel = 5'b00001;
                3'd1:    w_wr_sel = 5'b00010;
                3'd2:    w_wr_sel = 5'b00100;
                3'd3:    w_wr_sel = 5'b01000;
                3'd4:    w_wr_sel = 5'b10000;
                default: w_wr_sel = 5'b00000;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_werr   <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_wstate <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_waddr <= axi_awaddr;
                r_werr  <= 1'b0;
            end else if (w_w_hs) begin
                r_waddr <= r_waddr + DW'(4);
                r_werr  <= r_werr | w_wr_bad;
                if (axi_wlast) r_bresp <= (r_werr | w_wr_bad) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // A bus write to either MTIME half wins over the prescaled increment in the same cycle
    always_comb begin
        w_tick      = r_ctrl[0] && (r_presc == r_ctrl[15:8]);
        w_mtime_nxt = w_tick ? r_mtime + TW'(1) : r_mtime;
        w_presc_nxt = r_presc;
        if (w_wr_sel[0]) w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], axi_wdata, axi_wstrb)};
        if (w_wr_sel[1]) w_mtime_nxt = {f_merge(r_mtime[63:32], axi_wdata, axi_wstrb), r_mtime[31:0]};
        if (w_wr_sel[4]) begin
            w_presc_nxt = '0;
        end else if (r_ctrl[0]) begin
            w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_ctrl     <= CTRL_RESET;
            r_presc    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nxt;
            r_presc <= w_presc_nxt;
            r_irq   <= (r_mtime >= r_mtimecmp);
            if (w_wr_sel[2]) r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], axi_wdata, axi_wstrb);
            if (w_wr_sel[3]) r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], axi_wdata, axi_wstrb);
            if (w_wr_sel[4]) r_ctrl <= f_merge(r_ctrl, axi_wdata, axi_wstrb);
        end
    end

    assign axi_arready = (r_rstate == R_IDLE);
    assign axi_rvalid  = (r_rstate == R_DATA);
    assign axi_rdata   = r_rdata;
    assign axi_rresp   = r_rresp;
    assign axi_rlast   = r_rlast;
    assign axi_awready = (r_wstate == W_IDLE);
    assign axi_wready  = (r_wstate == W_DATA);
    assign axi_bvalid  = (r_wstate == W_RESP);
    assign axi_bresp   = r_bresp;
    assign timer_irq   = r_irq;

endmodule
